trail_writer: RTL and testbench

Writer side of the shared frameRAM frame buffer: paints Blue and Red light-cycle trail cells into video memory, while the display path reads packed pixels for scan-out.
- After reset it sweeps the whole buffer to the background colour.
- On each frame tick it writes the current trail cell for each live bike.
- Drives the frameRAM write port (data_In, write_address, we); the display path owns the read port.

---
 rtl/tron_pkg.sv | 28 ++
 rtl/sync_edge.sv | 27 ++
 rtl/trail_writer.sv | 201 ++++++++++++++++++++
 tb/tb_trail_writer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared types and constants for the light-cycle frame buffer writer.
package tron_pkg;

  typedef enum logic [3:0] {
    BG         = 4'h8,
    BLUE_TRAIL = 4'h1,
    RED_TRAIL  = 4'h2,
    BIKE       = 4'hF,
    BLOCKED    = 4'h7
  } color_e;

  localparam int unsigned FB_WORDS  = 153600;
  localparam int unsigned FB_STRIDE = 320;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    BURST = 2'd2
  } wr_state_e;

  // Both pixel nibbles of a word carry the same colour; the spare nibbles stay zero.
  function automatic logic [15:0] pack_word(input color_e c);
    logic [3:0] n;
    n = c;
    return {4'h0, n, 4'h0, n};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q, rise_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/trail_writer.sv
// Frame buffer writer: clears video memory after reset, then paints one
// trail cell per live bike on every frame tick through the frameRAM write port.
module trail_writer
  import tron_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int TRAIL_ROWS = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  Blue_X_real,
  input  logic [9:0]  Blue_Y_real,
  input  logic [9:0]  Red_X_real,
  input  logic [9:0]  Red_Y_real,
  input  logic        blue_alive,
  input  logic        red_alive,
  output logic [18:0] write_address,
  output logic [15:0] Data_Out,
  output logic        WE,
  output logic        busy,
  output logic        clear_done
);

  localparam logic [17:0] LAST_WORD = 18'(FB_WORDS - 1);
  localparam logic [2:0]  LAST_SLOT = 3'(2 * TRAIL_ROWS - 1);
  localparam logic [2:0]  ROWS      = 3'(TRAIL_ROWS);

  wr_state_e   state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [2:0]  slot_q, slot_d;
  logic        pend_q, pend_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        we_q, we_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [9:0]  bx_q, by_q, rx_q, ry_q;
  logic        ba_q, ra_q;
  logic        latch_s, load_s, tick_s;

  sync_edge u_frame_sync (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .async_i(frame_clk),
    .rise_o (tick_s)
  );

  // An idle tick emits slot 0 straight from the live inputs so the write lands in T+1.
  assign load_s = (state_q == IDLE) && tick_s;

  logic [2:0]  cur_slot_s, row_s;
  logic        is_red_s, alive_s, slot_we_s;
  logic [9:0]  sx_s, sy_s;
  logic [10:0] yr_s;
  logic [18:0] slot_addr_s;
  logic [15:0] slot_data_s;

  always_comb begin
    cur_slot_s = load_s ? 3'd0 : slot_q;
    is_red_s   = (cur_slot_s >= ROWS);
    row_s      = is_red_s ? (cur_slot_s - ROWS) : cur_slot_s;
    if (is_red_s) begin
      sx_s        = load_s ? Red_X_real : rx_q;
      sy_s        = load_s ? Red_Y_real : ry_q;
      alive_s     = load_s ? red_alive  : ra_q;
      slot_data_s = pack_word(RED_TRAIL);
    end else begin
      sx_s        = load_s ? Blue_X_real : bx_q;
      sy_s        = load_s ? Blue_Y_real : by_q;
      alive_s     = load_s ? blue_alive  : ba_q;
      slot_data_s = pack_word(BLUE_TRAIL);
    end
    yr_s        = {1'b0, sy_s} + {8'b0, row_s};
    slot_addr_s = {10'b0, sx_s[9:1]} + ({8'b0, yr_s} << 8) + ({8'b0, yr_s} << 6);
    slot_we_s   = alive_s && ({1'b0, sx_s} < H_RES[10:0]) && (yr_s < V_RES[10:0]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    pend_d  = pend_q;
    done_d  = done_q;
    busy_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    latch_s = 1'b0;
    case (state_q)
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = {1'b0, cnt_q};
        data_d = pack_word(BG);
        busy_d = 1'b1;
        if (cnt_q == LAST_WORD) begin
          cnt_d  = 18'd0;
          done_d = 1'b1;
          slot_d = 3'd0;
          if (pend_q || tick_s) begin
            latch_s = 1'b1;
            pend_d  = 1'b0;
            state_d = BURST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d  = cnt_q + 18'd1;
          pend_d = pend_q | tick_s;
        end
      end
      IDLE: begin
        if (tick_s) begin
          latch_s = 1'b1;
          we_d    = slot_we_s;
          addr_d  = slot_addr_s;
          data_d  = slot_data_s;
          busy_d  = 1'b1;
          slot_d  = 3'd1;
          state_d = BURST;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        we_d   = slot_we_s;
        addr_d = slot_addr_s;
        data_d = slot_data_s;
        busy_d = 1'b1;
        if (slot_q == LAST_SLOT) begin
          slot_d = 3'd0;
          if (pend_q || tick_s) begin
            latch_s = 1'b1;
            pend_d  = 1'b0;
            state_d = BURST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          slot_d = slot_q + 3'd1;
          pend_d = pend_q | tick_s;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = 18'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= CLEAR;
      cnt_q   <= 18'd0;
      slot_q  <= 3'd0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 19'd0;
      data_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Coordinates are frozen for the whole burst so mid-burst motion cannot tear a cell.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bx_q <= 10'd0;
      by_q <= 10'd0;
      rx_q <= 10'd0;
      ry_q <= 10'd0;
      ba_q <= 1'b0;
      ra_q <= 1'b0;
    end else if (latch_s) begin
      bx_q <= Blue_X_real;
      by_q <= Blue_Y_real;
      rx_q <= Red_X_real;
      ry_q <= Red_Y_real;
      ba_q <= blue_alive;
      ra_q <= red_alive;
    end
  end

  assign write_address = addr_q;
  assign Data_Out      = data_q;
  assign WE            = we_q;
  assign busy          = busy_q;
  assign clear_done    = done_q;

endmodule

// File: tb/tb_trail_writer.sv
// Scoreboard bench for trail_writer: expected writes are queued from a small
// model when a tick is issued and compared with the writes the DUT produces.
module tb_trail_writer;

  localparam int TR  = 2;
  localparam int FBW = 153600;

  typedef struct {
    logic [18:0] a;
    logic [15:0] d;
  } wr_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [9:0]  Blue_X_real = 10'd0, Blue_Y_real = 10'd0;
  logic [9:0]  Red_X_real = 10'd0, Red_Y_real = 10'd0;
  logic        blue_alive = 1'b0, red_alive = 1'b0;
  logic [18:0] write_address;
  logic [15:0] Data_Out;
  logic        WE, busy, clear_done;

  int n_checks = 0;
  int n_fail   = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  trail_writer #(.H_RES(640), .V_RES(480), .TRAIL_ROWS(TR)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .Blue_X_real  (Blue_X_real),
    .Blue_Y_real  (Blue_Y_real),
    .Red_X_real   (Red_X_real),
    .Red_Y_real   (Red_Y_real),
    .blue_alive   (blue_alive),
    .red_alive    (red_alive),
    .write_address(write_address),
    .Data_Out     (Data_Out),
    .WE           (WE),
    .busy         (busy),
    .clear_done   (clear_done)
  );

  always #5 Clk = ~Clk;

  function automatic void push_bike(input int x, input int y, input logic alive, input logic [15:0] word);
    for (int r = 0; r < TR; r++) begin
      if (alive && x < 640 && (y + r) < 480) begin
        exp_q.push_back('{a: 19'((x / 2) + (y + r) * 320), d: word});
      end
    end
  endfunction

  task automatic compare_burst(input string name, input int nbusy);
    n_checks++;
    if (nbusy !== 2 * TR) begin
      n_fail++;
      $display("FAIL %s burst_len: got %0d expected %0d", name, nbusy, 2 * TR);
    end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      wr_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (o.a !== e.a || o.d !== e.d) begin
        n_fail++;
        $display("FAIL %s write: got addr %0d data %h expected addr %0d data %h", name, o.a, o.d, e.a, e.d);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    n_checks++;
    if (WE !== 1'b0 || busy !== 1'b1 || clear_done !== 1'b0 || write_address !== 19'd0 || Data_Out !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got WE=%b busy=%b done=%b addr=%0d data=%h expected 0 1 0 0 0000",
               WE, busy, clear_done, write_address, Data_Out);
    end
    Reset = 1'b0;
  endtask

  // Full clear with two ticks at address ~1000; the single pending burst follows the last clear write.
  task automatic test_clear_and_pending();
    int wr_cnt, bad_addr, bad_data, not_busy, done_early, nb;
    wr_cnt = 0; bad_addr = 0; bad_data = 0; not_busy = 0; done_early = 0; nb = 0;
    Blue_X_real = 10'd200; Blue_Y_real = 10'd10; blue_alive = 1'b1;
    Red_X_real = 10'd300;  Red_Y_real = 10'd300; red_alive = 1'b0;
    for (int i = 0; i < 160000 && wr_cnt < FBW; i++) begin
      @(negedge Clk);
      if (WE) begin
        if (write_address !== 19'(wr_cnt)) bad_addr++;
        if (Data_Out !== 16'h0808) bad_data++;
        wr_cnt++;
      end
      if (!busy) not_busy++;
      if (clear_done && wr_cnt < FBW) done_early++;
      frame_clk = (wr_cnt >= 1000 && wr_cnt < 1010) || (wr_cnt >= 1020 && wr_cnt < 1030);
      if (wr_cnt == 100000) begin
        Blue_X_real = 10'd100;
        Blue_Y_real = 10'd50;
      end
    end
    n_checks++;
    if (wr_cnt !== FBW) begin n_fail++; $display("FAIL clear_count: got %0d expected %0d", wr_cnt, FBW); end
    n_checks++;
    if (bad_addr !== 0) begin n_fail++; $display("FAIL clear_addr_seq: got %0d bad expected 0", bad_addr); end
    n_checks++;
    if (bad_data !== 0) begin n_fail++; $display("FAIL clear_data: got %0d bad expected 0", bad_data); end
    n_checks++;
    if (not_busy !== 0) begin n_fail++; $display("FAIL clear_busy: got %0d idle cycles expected 0", not_busy); end
    n_checks++;
    if (done_early !== 0) begin n_fail++; $display("FAIL clear_done_early: got %0d expected 0", done_early); end
    push_bike(100, 50, 1'b1, 16'h0101);
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (!busy) break;
      nb++;
      if (WE) obs_q.push_back('{a: write_address, d: Data_Out});
    end
    compare_burst("pending_after_clear", nb);
    n_checks++;
    if (clear_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_clear: got done=%b busy=%b expected 1 0", clear_done, busy);
    end
    repeat (6) @(negedge Clk);
  endtask

  task automatic test_burst(input string name, input int bx, input int by, input logic ba,
                            input int rx, input int ry, input logic ra);
    int nb, timeout;
    Blue_X_real = 10'(bx); Blue_Y_real = 10'(by); blue_alive = ba;
    Red_X_real = 10'(rx);  Red_Y_real = 10'(ry);  red_alive = ra;
    push_bike(bx, by, ba, 16'h0101);
    push_bike(rx, ry, ra, 16'h0202);
    nb = 0; timeout = 1;
    frame_clk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (busy) begin timeout = 0; break; end
    end
    n_checks++;
    if (timeout !== 0) begin n_fail++; $display("FAIL %s start: got no busy within 20 cycles expected busy", name); end
    for (int i = 0; i < 16 && timeout == 0; i++) begin
      if (!busy) break;
      nb++;
      if (WE) obs_q.push_back('{a: write_address, d: Data_Out});
      if (WE && write_address > 19'd153599) begin
        n_checks++; n_fail++;
        $display("FAIL %s addr_range: got %0d expected <= 153599", name, write_address);
      end
      Blue_X_real = 10'd7; Blue_Y_real = 10'd7;
      @(negedge Clk);
    end
    frame_clk = 1'b0;
    compare_burst(name, nb);
    repeat (6) @(negedge Clk);
  endtask

  task automatic test_reset_mid_burst();
    int timeout;
    Blue_X_real = 10'd100; Blue_Y_real = 10'd50; blue_alive = 1'b1;
    Red_X_real = 10'd200;  Red_Y_real = 10'd100; red_alive = 1'b1;
    timeout = 1;
    frame_clk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (busy) begin timeout = 0; break; end
    end
    n_checks++;
    if (timeout !== 0 || WE !== 1'b1 || write_address !== 19'd16050) begin
      n_fail++;
      $display("FAIL rst_burst_slot0: got timeout=%0d WE=%b addr=%0d expected 0 1 16050", timeout, WE, write_address);
    end
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (WE !== 1'b0 || clear_done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_burst_state: got WE=%b done=%b busy=%b expected 0 0 1", WE, clear_done, busy);
    end
    Reset = 1'b0;
    frame_clk = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (WE !== 1'b1 || write_address !== 19'd0 || Data_Out !== 16'h0808 || clear_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_burst_restart: got WE=%b addr=%0d data=%h done=%b expected 1 0 0808 0",
               WE, write_address, Data_Out, clear_done);
    end
  endtask

  initial begin
    test_reset();
    test_clear_and_pending();
    test_burst("blue_only",   100, 50, 1'b1, 300, 300, 1'b0);
    test_burst("blue_odd_x",  101, 50, 1'b1, 300, 300, 1'b0);
    test_burst("red_corner",  0, 0, 1'b0, 638, 479, 1'b1);
    test_burst("blue_offscr", 640, 10, 1'b1, 5, 5, 1'b0);
    test_burst("both_alive",  0, 0, 1'b1, 10, 5, 1'b1);
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
